// File: rtl/updown_counter_mod.sv
// Parametrised up/down event counter with programmable step, run-time
// modulo limit, wrap/saturate behaviour, a terminal-count pulse and sticky
// overflow/underflow flags. Arithmetic is carried in WIDTH+1 bits so that a
// sum or wrap-around never loses its carry before it is compared with limit.
module updown_counter_mod #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              load,
    input  logic              enable,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic              mode,
    input  logic [WIDTH-1:0]  limit,
    input  logic              clear_flags,
    output logic [WIDTH-1:0]  data_out,
    output logic              tc,
    output logic              overflow,
    output logic              underflow,
    output logic              at_max,
    output logic              at_zero
);

    // Width large enough to compare step against limit without truncating either.
    localparam int CW = (STEP_W > WIDTH) ? (STEP_W + 1) : (WIDTH + 1);

    localparam logic [WIDTH:0]   ONE_X  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    // State registers
    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             overflow_r;
    logic             underflow_r;

    // Next-state values
    logic [WIDTH-1:0] count_next_s;
    logic             tc_next_s;
    logic             ovf_set_s;
    logic             udf_set_s;
    logic             overflow_next_s;
    logic             underflow_next_s;

    // Widened operands
    logic [CW-1:0]    step_c_s;
    logic [CW-1:0]    limit_c_s;
    logic [CW-1:0]    step_min_c_s;
    logic [WIDTH:0]   eff_step_s;
    logic [WIDTH:0]   count_x_s;
    logic [WIDTH:0]   limit_x_s;
    logic [WIDTH:0]   limit_plus1_s;
    logic [WIDTH:0]   up_sum_s;
    logic [WIDTH-1:0] load_val_s;

    assign step_c_s      = {{(CW - STEP_W){1'b0}}, step};
    assign limit_c_s     = {{(CW - WIDTH){1'b0}}, limit};
    assign step_min_c_s  = (step_c_s < limit_c_s) ? step_c_s : limit_c_s;
    // The clamped step never exceeds limit, so it always fits in WIDTH+1 bits.
    assign eff_step_s    = (WIDTH + 1)'(step_min_c_s);
    assign count_x_s     = {1'b0, count_r};
    assign limit_x_s     = {1'b0, limit};
    assign limit_plus1_s = limit_x_s + ONE_X;
    assign up_sum_s      = count_x_s + eff_step_s;
    assign load_val_s    = (data_in < limit) ? data_in : limit;

    // Next count, crossing detection and terminal-count request for this cycle.
    always_comb begin
        count_next_s = count_r;
        tc_next_s    = 1'b0;
        ovf_set_s    = 1'b0;
        udf_set_s    = 1'b0;
        if (load) begin
            count_next_s = load_val_s;
        end else if (enable) begin
            if (count_x_s > limit_x_s) begin
                // limit was lowered below the current count: pull back into range
                count_next_s = limit;
            end else if (eff_step_s == {(WIDTH + 1){1'b0}}) begin
                count_next_s = count_r;
            end else if (up_down) begin
                if (up_sum_s > limit_x_s) begin
                    tc_next_s = 1'b1;
                    ovf_set_s = 1'b1;
                    if (mode) begin
                        count_next_s = limit;
                    end else begin
                        count_next_s = WIDTH'(up_sum_s - limit_plus1_s);
                    end
                end else begin
                    count_next_s = WIDTH'(up_sum_s);
                end
            end else begin
                if (eff_step_s > count_x_s) begin
                    tc_next_s = 1'b1;
                    udf_set_s = 1'b1;
                    if (mode) begin
                        count_next_s = ZERO_W;
                    end else begin
                        count_next_s = WIDTH'(count_x_s + limit_plus1_s - eff_step_s);
                    end
                end else begin
                    count_next_s = WIDTH'(count_x_s - eff_step_s);
                end
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Sticky flags: a new crossing takes precedence over a clear request.
    always_comb begin
        overflow_next_s  = overflow_r;
        underflow_next_s = underflow_r;
        if (ovf_set_s) begin
            overflow_next_s = 1'b1;
        end else if (clear_flags) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
        if (udf_set_s) begin
            underflow_next_s = 1'b1;
        end else if (clear_flags) begin
            underflow_next_s = 1'b0;
        end else begin
            underflow_next_s = underflow_r;
        end
    end

    // Register count, terminal-count pulse and flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r     <= ZERO_W;
            tc_r        <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            tc_r        <= tc_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
        end
    end

    assign data_out  = count_r;
    assign tc        = tc_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
    assign at_max    = (count_r == limit);
    assign at_zero   = (count_r == ZERO_W);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod: directed scenarios followed by
// randomized cycles, all compared against an integer-arithmetic reference.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       load = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b0;
    logic [3:0] step = 4'd0;
    logic       mode = 1'b0;
    logic [7:0] limit = 8'd0;
    logic       clear_flags = 1'b0;
    logic [7:0] data_out;
    logic       tc;
    logic       overflow;
    logic       underflow;
    logic       at_max;
    logic       at_zero;

    int checks = 0;
    int errors = 0;

    // Reference state
    int m_cnt = 0;
    int m_tc  = 0;
    int m_ovf = 0;
    int m_udf = 0;

    updown_counter_mod #(.WIDTH(8), .STEP_W(4)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .enable(enable), .up_down(up_down), .step(step), .mode(mode),
        .limit(limit), .clear_flags(clear_flags), .data_out(data_out),
        .tc(tc), .overflow(overflow), .underflow(underflow),
        .at_max(at_max), .at_zero(at_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Behavioural model: applies the counting rules with plain integers.
    task automatic model(input int r, ld, en, ud, st, md, lim, din, clr);
        int s, n_tc, so, su;
        so = 0; su = 0; n_tc = 0;
        s = (st < lim) ? st : lim;
        if (r != 0) begin
            m_cnt = 0; m_tc = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (ld != 0) begin
                m_cnt = (din < lim) ? din : lim;
            end else if (en != 0) begin
                if (m_cnt > lim) begin
                    m_cnt = lim;
                end else if (s == 0) begin
                    m_cnt = m_cnt;
                end else if (ud != 0) begin
                    if (m_cnt + s > lim) begin
                        n_tc = 1; so = 1;
                        m_cnt = (md != 0) ? lim : (m_cnt + s) % (lim + 1);
                    end else begin
                        m_cnt = m_cnt + s;
                    end
                end else begin
                    if (s > m_cnt) begin
                        n_tc = 1; su = 1;
                        m_cnt = (md != 0) ? 0 : (m_cnt - s + lim + 1) % (lim + 1);
                    end else begin
                        m_cnt = m_cnt - s;
                    end
                end
            end
            m_tc = n_tc;
            if (so != 0) m_ovf = 1; else if (clr != 0) m_ovf = 0;
            if (su != 0) m_udf = 1; else if (clr != 0) m_udf = 0;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic cyc(input int r, ld, en, ud, st, md, lim, din, clr);
        reset = r[0]; load = ld[0]; enable = en[0]; up_down = ud[0];
        step = st[3:0]; mode = md[0]; limit = lim[7:0]; data_in = din[7:0];
        clear_flags = clr[0];
        model(r, ld, en, ud, st, md, lim, din, clr);
        @(posedge clk);
        #1;
        check("data_out", int'(data_out), m_cnt);
        check("tc", int'(tc), m_tc);
        check("overflow", int'(overflow), m_ovf);
        check("underflow", int'(underflow), m_udf);
        check("at_max", int'(at_max), (m_cnt == lim) ? 1 : 0);
        check("at_zero", int'(at_zero), (m_cnt == 0) ? 1 : 0);
    endtask

    initial begin
        int lim_r, tc_seen;
        @(posedge clk);
        #1;
        // Reset for two cycles
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_data_out", int'(data_out), 0);
        check("reset_flags", int'({tc, overflow, underflow}), 0);

        // Wrap count to 9 and around
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1, 1, 0, 9, 0, 0);
        check("wrap_final", int'(data_out), 2);
        check("wrap_ovf", int'(overflow), 1);

        // Load clamp, then saturate at limit twice
        cyc(0, 1, 0, 1, 3, 1, 9, 20, 0);
        check("load_clamp", int'(data_out), 9);
        cyc(0, 0, 1, 1, 3, 1, 9, 0, 0);
        check("sat_tc1", int'(tc), 1);
        cyc(0, 0, 1, 1, 3, 1, 9, 0, 0);
        check("sat_tc2", int'(tc), 1);
        check("sat_hold", int'(data_out), 9);

        // Down crossing, wrap then saturate
        cyc(0, 1, 0, 0, 7, 0, 200, 5, 0);
        cyc(0, 0, 1, 0, 7, 0, 200, 0, 0);
        check("down_wrap", int'(data_out), 199);
        check("down_udf", int'(underflow), 1);
        cyc(0, 1, 0, 0, 7, 1, 200, 5, 0);
        cyc(0, 0, 1, 0, 7, 1, 200, 0, 0);
        check("down_sat", int'(data_out), 0);

        // Set beats clear in the same cycle; clear alone then clears
        cyc(0, 1, 0, 1, 1, 0, 9, 9, 0);
        cyc(0, 0, 1, 1, 1, 0, 9, 0, 1);
        check("set_wins", int'(overflow), 1);
        cyc(0, 0, 0, 1, 1, 0, 9, 0, 1);
        check("clear_ovf", int'(overflow), 0);

        // Limit lowered below the current count
        cyc(0, 1, 0, 1, 1, 0, 255, 150, 0);
        cyc(0, 0, 1, 1, 1, 0, 255, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 100, 0, 0);
        check("limit_lower", int'(data_out), 100);
        check("limit_lower_tc", int'(tc), 0);

        // Reset wins over load and enable
        cyc(1, 1, 1, 1, 5, 0, 100, 50, 0);
        check("rst_prio", int'({data_out, tc, overflow, underflow}), 0);

        // limit == 0: stays at zero, never a terminal count
        tc_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, i % 2, 15, i / 2 % 2, 0, 0, 0);
            tc_seen = tc_seen | int'(tc);
        end
        check("lim0_cnt", int'(data_out), 0);
        check("lim0_tc", tc_seen, 0);

        // Randomized cycles, limit biased to small values and full range
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: lim_r = $urandom_range(0, 12);
                1: lim_r = 255;
                default: lim_r = $urandom_range(0, 255);
            endcase
            cyc(($urandom_range(0, 63) == 0) ? 1 : 0,
                ($urandom_range(0, 9) == 0) ? 1 : 0,
                ($urandom_range(0, 9) < 8) ? 1 : 0,
                $urandom_range(0, 1), $urandom_range(0, 15),
                $urandom_range(0, 1), lim_r, $urandom_range(0, 255),
                ($urandom_range(0, 7) == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
